// File: rtl/lab1_fp_decode_if.sv
// rtl/lab1_fp_decode_if.sv - handshake bundle between the fp word producer, the decoder and its consumer
interface lab1_fp_decode_if #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic             S;
    logic [EXP_W-1:0] E;
    logic [SIG_W-1:0] F;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] D;

    // master drives words in and consumes results; slave is the decoder
    modport master (
        output in_valid, S, E, F, out_ready,
        input  in_ready, out_valid, D
    );

    modport slave (
        input  in_valid, S, E, F, out_ready,
        output in_ready, out_valid, D
    );
endinterface

// File: rtl/lab1_fp_decode.sv
// rtl/lab1_fp_decode.sv - serial decoder of S/E/F float words into two's-complement linear values
module lab1_fp_decode #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int OUT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    lab1_fp_decode_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIX   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [EXP_W-1:0] cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic [OUT_W-1:0] d_q, d_d;
    logic             out_valid_q, out_valid_d;

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sgn_d       = sgn_q;
        d_d         = d_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    acc_d   = OUT_W'(bus.F);
                    cnt_d   = bus.E;
                    sgn_d   = bus.S;
                    state_d = (bus.E != '0) ? ST_SHIFT : ST_FIX;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_q << 1;
                cnt_d = cnt_q - EXP_W'(1);
                if (cnt_q == EXP_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                // S=1 with a zero magnitude negates to zero, so no negative zero appears
                d_d         = sgn_q ? (~acc_q + OUT_W'(1)) : acc_q;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sgn_q       <= sgn_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_lab1_fp_decode.sv
// tb/tb_lab1_fp_decode.sv - directed checks of lab1_fp_decode latency, arithmetic, backpressure and reset
module tb_lab1_fp_decode;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;

    lab1_fp_decode_if bus ();

    lab1_fp_decode dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [15:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
        int v;
        v = int'(f) * (1 << e);
        if (s) v = -v;
        return 16'(v) & 16'h0FFF;
    endfunction

    // present one word, accept it, then wait for out_valid and check latency and value
    task automatic run(input string tag, input logic s, input logic [2:0] e, input logic [3:0] f,
                       input logic [15:0] exp_d);
        int lat;
        check({tag, "_in_ready"}, 16'(bus.in_ready), 16'd1);
        bus.S = s;
        bus.E = e;
        bus.F = f;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'(int'(e) + 1));
        check({tag, "_D"}, 16'(bus.D), exp_d);
    endtask

    int         acc_cyc [16];
    logic [2:0] e_hist  [16];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        rst      = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.S = 1'b0;
        bus.E = '0;
        bus.F = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_in_ready", 16'(bus.in_ready), 16'd1);
        check("rst_out_valid", 16'(bus.out_valid), 16'd0);
        check("rst_D", 16'(bus.D), 16'h000);

        bus.out_ready = 1'b1;
        run("e0", 1'b0, 3'd0, 4'b0101, 16'h005);
        step();
        check("e0_back_idle", 16'(bus.in_ready), 16'd1);
        check("e0_valid_drop", 16'(bus.out_valid), 16'd0);
        check("e0_D_kept", 16'(bus.D), 16'h005);

        run("max_pos", 1'b0, 3'd7, 4'b1111, 16'h780);
        step();
        run("max_neg", 1'b1, 3'd7, 4'b1111, 16'h880);
        step();
        run("neg64", 1'b1, 3'd3, 4'b1000, 16'hFC0);
        step();
        run("negzero", 1'b1, 3'd0, 4'b0000, 16'h000);
        step();

        bus.out_ready = 1'b0;
        run("bp", 1'b0, 3'd2, 4'b0011, 16'h00C);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.S = 1'b1;
            bus.E = 3'd5;
            bus.F = 4'(i + 3);
            step();
            check("bp_hold_valid", 16'(bus.out_valid), 16'd1);
            check("bp_hold_D", 16'(bus.D), 16'h00C);
            check("bp_in_ready", 16'(bus.in_ready), 16'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        check("bp_release_valid", 16'(bus.out_valid), 16'd0);
        check("bp_release_idle", 16'(bus.in_ready), 16'd1);
        step();
        check("bp_no_capture_valid", 16'(bus.out_valid), 16'd0);
        check("bp_no_capture_D", 16'(bus.D), 16'h00C);

        bus.S = 1'b0;
        bus.E = 3'd6;
        bus.F = 4'b1011;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 16'(bus.out_valid), 16'd0);
        check("midrst_D", 16'(bus.D), 16'h000);
        check("midrst_in_ready", 16'(bus.in_ready), 16'd1);
        run("post_rst", 1'b0, 3'd1, 4'b1001, 16'h012);
        step();

        // in_valid stays high; each new word is presented as soon as the block is idle again
        bus.in_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            logic       s;
            logic [2:0] e;
            logic [3:0] f;
            int         lat;
            s = 1'($urandom_range(0, 1));
            e = 3'($urandom_range(0, 7));
            f = 4'($urandom_range(0, 15));
            bus.S = s;
            bus.E = e;
            bus.F = f;
            lat = 0;
            while (!bus.in_ready && lat < 20) begin
                step();
                lat++;
            end
            check("b2b_ready", 16'(bus.in_ready), 16'd1);
            step();
            acc_cyc[k] = cyc;
            e_hist[k]  = e;
            if (k > 0) begin
                check("b2b_spacing", 16'(acc_cyc[k] - acc_cyc[k-1]), 16'(int'(e_hist[k-1]) + 3));
            end
            lat = 0;
            while (!bus.out_valid && lat < 20) begin
                step();
                lat++;
            end
            check("b2b_latency", 16'(lat), 16'(int'(e) + 1));
            check("b2b_D", 16'(bus.D), model(s, e, f));
            step();
        end
        bus.in_valid = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lab1_fp_decode.md
Name: lab1_fp_decode

Overview:
- Reverse direction of the lab1 linear-to-float encoder/rounder.
- Accepts one 8-bit floating-point word per transaction: sign S, 3-bit exponent E, 4-bit significand F.
- Reconstructs the 12-bit two's-complement value V = (−1)^S × F × 2^E using a serial shift datapath.
- Sits downstream of the encoder output so decoded values can be compared against the original linear inputs. Valid/ready handshake on both sides.

Parameters:
- EXP_W, 3, exponent width.
- SIG_W, 4, significand width.
- OUT_W, 12, output width. Must satisfy OUT_W ≥ SIG_W + 2^EXP_W. Defaults give exactly 12.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept; high only in IDLE.
- S  in  1  sign bit.
- E  in  EXP_W  exponent.
- F  in  SIG_W  significand.
- out_valid  out  1  D holds a completed result.
- out_ready  in  1  consumer accepts D.
- D  out  OUT_W  decoded two's-complement value.

Behaviour:
- Reset: rst sampled high at a clk edge forces IDLE, out_valid=0, D=0, internal accumulator/counter/sign=0. in_ready=1 from the first cycle after reset. Inputs are ignored while rst is high.
- Reset mid-operation: any in-flight transaction is discarded. No partial D is ever presented.
- in_ready is combinational: (state==IDLE). out_valid is registered: (state==DONE).
- IDLE:
  - On an edge with in_valid&&in_ready: acc←zero-extended F; cnt←E; sgn←S.
  - Next state is SHIFT if E≠0, else FIX.
- SHIFT:
  - Each edge: acc←acc<<1; cnt←cnt−1.
  - When cnt==1 at the edge, next state is FIX.
  - Exactly E shift edges occur.
- FIX: one edge. D←sgn ? (~acc+1) : acc, truncated to OUT_W; next state is DONE.
- DONE:
  - D and out_valid held stable until out_ready is sampled high.
  - On out_valid&&out_ready: next state is IDLE, out_valid←0, and D keeps its last value.
  - No same-cycle accept of a new input while leaving DONE; the earliest next accept is one edge later.
- Latency: out_valid rises on the (E+1)th rising edge after the accepting edge. Range is 1 to 8 cycles. Minimum initiation interval is E+3 cycles with out_ready held high.
- Arithmetic:
  - No overflow is possible: max magnitude is 15×128 = 1920 < 2047.
  - S=1 with F=0 yields D=0 (no negative zero).
  - Non-normalized F (MSB=0) is decoded literally, with no error flag.
- Inputs S/E/F are sampled only on the accepting edge. Changes afterwards have no effect.
- in_valid outside IDLE is ignored. No queuing.

Test Plan:
- S=0,E=0,F=4'b0101, out_ready=1 -> out_valid high 1 edge after accept, D=12'h005, in_ready back high the following cycle.
- S=0,E=7,F=4'b1111 -> out_valid after 8 edges, D=12'h780 (1920). Also S=1,E=7,F=4'b1111 -> D=12'h880 (−1920).
- S=1,E=3,F=4'b1000 -> D=12'hFC0 (−64) after 4 edges. S=1,E=0,F=0 -> D=12'h000.
- Backpressure: complete S=0,E=2,F=4'b0011 (D=12'h00C). Hold out_ready=0 for 5 cycles and pulse in_valid with other data meanwhile -> D and out_valid stable, in_ready=0, second word not captured. Raise out_ready -> one transfer, then IDLE.
- Reset mid-SHIFT: accept E=6, assert rst on the 3rd shift edge -> next cycle out_valid=0, D=0, in_ready=1. A new word S=0,E=1,F=4'b1001 then decodes to 12'h012.
- Back-to-back: 16 random words with out_ready=1 and in_valid held high -> each D matches the (−1)^S·F·2^E reference model, and the spacing between accepts equals E+3 cycles.
